// File: rtl/half_subtractor_sync_pkg.sv
// Shared lane definitions for the registered half subtractor.
// hs_lane_ref is the golden one-lane result used by the embedded assertions.
package half_subtractor_sync_pkg;

    // Packed one-lane result {borrow, diff}
    typedef struct packed {
        logic borrow;
        logic diff;
    } hs_lane_t;

    localparam int unsigned HsLaneBits = 2;

    function automatic hs_lane_t hs_lane_ref(input logic a, input logic b);
        hs_lane_t r;
        r.diff   = a ^ b;
        r.borrow = ~a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_sub_cell.sv
// One-bit combinational half subtractor: d = a - b (mod 2), bo = borrow out.
module half_sub_cell (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule

// File: rtl/half_subtractor_sync.sv
// Bit-parallel half subtractor: WIDTH independent lanes with an optional
// output register stage (synchronous active-low reset) or a combinational bypass.
module half_subtractor_sync
    import half_subtractor_sync_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic [WIDTH-1:0] Borrow
);

    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] borrow_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_sub_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .d  (diff_d[i]),
            .bo (borrow_d[i])
        );
    end

    if (OUT_REG) begin : g_out_reg
        logic [WIDTH-1:0] diff_q;
        logic [WIDTH-1:0] borrow_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                diff_q   <= '0;
                borrow_q <= '0;
            end else begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
            end
        end

        assign Diff   = diff_q;
        assign Borrow = borrow_q;
    end else begin : g_out_comb
        // clk and rst_n are intentionally unused in this configuration
        assign Diff   = diff_d;
        assign Borrow = borrow_d;
    end

`ifndef SYNTHESIS
    for (genvar i = 0; i < WIDTH; i++) begin : g_sva
        a_borrow_implies_diff : assert property (@(posedge clk) Borrow[i] |-> Diff[i]);

        if (OUT_REG) begin : g_reg_eq
            a_one_cycle_ref : assert property (@(posedge clk)
                $past(rst_n) |->
                ({Borrow[i], Diff[i]} == hs_lane_ref($past(A[i]), $past(B[i]))));
        end
    end
`endif

endmodule

// File: tb/tb_half_subtractor_sync.sv
// Self-checking bench: four DUT configurations checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed results.
module tb_half_subtractor_sync;

    logic       clk;
    logic       rst_n;
    logic [0:0] a1, b1, d1, bo1;
    logic [3:0] a4, b4, d4, bo4;
    logic [7:0] a8, b8, d8, bo8;
    logic [0:0] ac, bc, dc, boc;

    int tests;
    int fails;

    half_subtractor_sync #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Diff(d1), .Borrow(bo1));
    half_subtractor_sync #(.WIDTH(4), .OUT_REG(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Diff(d4), .Borrow(bo4));
    half_subtractor_sync #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Diff(d8), .Borrow(bo8));
    half_subtractor_sync #(.WIDTH(1), .OUT_REG(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .A(ac), .B(bc), .Diff(dc), .Borrow(boc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: per lane, a - b as a 2-bit unsigned subtraction; bit 0 is the
    // difference, bit 1 the borrow (wraps to 2'b11 when negative).
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        logic [7:0] bo;
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            r     = {1'b0, a[i]} - {1'b0, b[i]};
            d[i]  = r[0];
            bo[i] = r[1];
        end
        return {bo, d};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected registered outputs, captured from the inputs at each rising edge
    logic        exp_valid;
    logic [15:0] exp1, exp4, exp8;

    initial exp_valid = 1'b0;

    always @(posedge clk) begin
        exp_valid <= 1'b1;
        if (!rst_n) begin
            exp1 <= '0;
            exp4 <= '0;
            exp8 <= '0;
        end else begin
            exp1 <= model({7'd0, a1}, {7'd0, b1});
            exp4 <= model({4'd0, a4}, {4'd0, b4});
            exp8 <= model(a8, b8);
        end
    end

    always @(negedge clk) begin
        logic [15:0] ec;
        if (exp_valid) begin
            check("w1_diff",   {7'd0, d1},  exp1[7:0]);
            check("w1_borrow", {7'd0, bo1}, exp1[15:8]);
            check("w4_diff",   {4'd0, d4},  exp4[7:0]);
            check("w4_borrow", {4'd0, bo4}, exp4[15:8]);
            check("w8_diff",   d8,          exp8[7:0]);
            check("w8_borrow", bo8,         exp8[15:8]);
        end
        ec = model({7'd0, ac}, {7'd0, bc});
        check("comb_diff",   {7'd0, dc},  ec[7:0]);
        check("comb_borrow", {7'd0, boc}, ec[15:8]);
    end

    initial begin
        logic [3:0] vec_a, vec_b, tab_d, tab_bo;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF;
        a8 = 8'hFF; b8 = 8'hFF;
        ac = 1'b0; bc = 1'b1;

        // Combinational instance responds before any clock edge, reset held low
        #1;
        check("comb_pre_edge_diff",   {7'd0, dc},  8'h01);
        check("comb_pre_edge_borrow", {7'd0, boc}, 8'h01);

        repeat (2) @(posedge clk);
        #1;
        check("reset_w1_diff",   {7'd0, d1},  8'h00);
        check("reset_w1_borrow", {7'd0, bo1}, 8'h00);
        check("reset_w8_diff",   d8,          8'h00);
        rst_n = 1'b1;

        // Exhaustive single lane: AB = 00, 01, 10, 11
        vec_a  = 4'b1100;
        vec_b  = 4'b1010;
        tab_d  = 4'b0110;
        tab_bo = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            a1 = vec_a[3-i];
            b1 = vec_b[3-i];
            @(posedge clk);
            #1;
            check("tt_diff",   {7'd0, d1},  {7'd0, tab_d[3-i]});
            check("tt_borrow", {7'd0, bo1}, {7'd0, tab_bo[3-i]});
        end

        // Reset in the middle of a 0 - 1 stream
        a1 = 1'b0; b1 = 1'b1;
        @(posedge clk); #1;
        check("stream_diff", {7'd0, d1}, 8'h01);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_diff",   {7'd0, d1},  8'h00);
        check("midrst_borrow", {7'd0, bo1}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_diff",   {7'd0, d1},  8'h01);
        check("post_rst_borrow", {7'd0, bo1}, 8'h01);

        // Four lanes at once, no inter-lane borrow
        a4 = 4'b1100; b4 = 4'b1010;
        @(posedge clk); #1;
        check("w4_vec_diff",   {4'd0, d4},  8'h06);
        check("w4_vec_borrow", {4'd0, bo4}, 8'h02);

        // Combinational bypass ignores reset
        rst_n = 1'b0;
        ac = 1'b0; bc = 1'b1;
        #1;
        check("comb_rst_diff",   {7'd0, dc},  8'h01);
        check("comb_rst_borrow", {7'd0, boc}, 8'h01);
        ac = 1'b1; bc = 1'b0;
        #1;
        check("comb_rst_10_borrow", {7'd0, boc}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic, checked every cycle by the compare process
        for (int n = 0; n < 1000; n++) begin
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            ac = 1'($urandom);
            bc = 1'($urandom);
            if (n % 97 == 50) rst_n = 1'b0;
            else rst_n = 1'b1;
            @(posedge clk); #1;
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
